// File: rtl/l2_layer_infer.sv
// Layer-2 inference stage.
// Maintains a 4-entry decaying time surface driven by the L1 spike lines. Each
// input event triggers a snapshot of that surface, a 4-step multiply-accumulate
// against the weights of 3 neurons, and a threshold comparison. The strongest
// neuron above its threshold emits a one-clock, one-hot spike.
module l2_layer_infer #(
  parameter int p_width     = 9,
  parameter int p_decay_div = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [3:0]                   i_event,
  input  logic [3*4*p_width-1:0]       i_weights,
  input  logic [3*(2*p_width+2)-1:0]   i_thresholds,
  output logic [2:0]                   o_spikeout,
  output logic [4*p_width-1:0]         o_ts,
  output logic [3*(2*p_width+2)-1:0]   o_lv,
  output logic                         o_busy
);

  localparam int PW = 2 * p_width + 2;
  localparam int DW = (p_decay_div > 1) ? $clog2(p_decay_div) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    MAC0 = 3'd2,
    MAC1 = 3'd3,
    MAC2 = 3'd4,
    MAC3 = 3'd5,
    CMP  = 3'd6,
    FIRE = 3'd7
  } state_t;

  state_t                        state_r;
  logic [DW-1:0]                 div_r;
  logic                          decay_tick_s;
  logic [3:0][p_width-1:0]       ts_r;
  logic [3:0][p_width-1:0]       snap_r;
  logic [2:0][PW-1:0]            acc_r;
  logic [2:0][PW-1:0]            lv_r;
  logic                          pend_r;
  logic                          any_event_s;
  logic [1:0]                    mac_sel_s;
  logic [2:0][3:0][p_width-1:0]  w_s;
  logic [2:0][PW-1:0]            thr_s;
  logic [p_width-1:0]            ts_sel_s;
  logic [2:0][PW-1:0]            prod_s;
  logic [2:0]                    cand_s;
  logic [2:0]                    win_s;

  assign any_event_s  = |i_event;
  assign w_s          = i_weights;
  assign thr_s        = i_thresholds;
  assign decay_tick_s = (div_r == DW'(p_decay_div - 1));
  assign o_ts         = snap_r;
  assign o_lv         = lv_r;

  // Free-running divider producing one decay tick every p_decay_div clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_r <= {DW{1'b0}};
    end else if (decay_tick_s) begin
      div_r <= {DW{1'b0}};
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Time surface: an event reloads all-ones, otherwise decay saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        ts_r[k] <= {p_width{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_event[k]) begin
          ts_r[k] <= {p_width{1'b1}};
        end else if (decay_tick_s && (ts_r[k] != {p_width{1'b0}})) begin
          ts_r[k] <= ts_r[k] - p_width'(1);
        end else begin
          ts_r[k] <= ts_r[k];
        end
      end
    end
  end

  // Select which time-surface input the current MAC step consumes.
  always_comb begin
    mac_sel_s = 2'd0;
    case (state_r)
      MAC0:    mac_sel_s = 2'd0;
      MAC1:    mac_sel_s = 2'd1;
      MAC2:    mac_sel_s = 2'd2;
      MAC3:    mac_sel_s = 2'd3;
      default: mac_sel_s = 2'd0;
    endcase
  end

  // Per-neuron product of the selected weight and snapshot entry.
  always_comb begin
    ts_sel_s = snap_r[mac_sel_s];
    for (int n = 0; n < 3; n++) begin
      prod_s[n] = PW'(w_s[n][mac_sel_s]) * PW'(ts_sel_s);
    end
  end

  // Winner: strictly above threshold, largest potential, lowest index on ties.
  always_comb begin
    cand_s = 3'b000;
    for (int n = 0; n < 3; n++) begin
      cand_s[n] = (acc_r[n] > thr_s[n]);
    end
    if (cand_s[0] && (!cand_s[1] || (acc_r[0] >= acc_r[1])) &&
        (!cand_s[2] || (acc_r[0] >= acc_r[2]))) begin
      win_s = 3'b001;
    end else if (cand_s[1] && (!cand_s[2] || (acc_r[1] >= acc_r[2]))) begin
      win_s = 3'b010;
    end else if (cand_s[2]) begin
      win_s = 3'b100;
    end else begin
      win_s = 3'b000;
    end
  end

  // Control FSM with registered snapshot, potentials, spike and busy outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      pend_r     <= 1'b0;
      o_busy     <= 1'b0;
      o_spikeout <= 3'b000;
      for (int k = 0; k < 4; k++) begin
        snap_r[k] <= {p_width{1'b0}};
      end
      for (int n = 0; n < 3; n++) begin
        acc_r[n] <= {PW{1'b0}};
        lv_r[n]  <= {PW{1'b0}};
      end
    end else begin
      // Events arriving mid-computation coalesce into one recomputation.
      if ((state_r != IDLE) && any_event_s) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          pend_r <= 1'b0;
          if (any_event_s) begin
            state_r <= SNAP;
            o_busy  <= 1'b1;
          end else begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        SNAP: begin
          snap_r <= ts_r;
          for (int n = 0; n < 3; n++) begin
            acc_r[n] <= {PW{1'b0}};
          end
          state_r <= MAC0;
        end
        MAC0, MAC1, MAC2: begin
          for (int n = 0; n < 3; n++) begin
            acc_r[n] <= acc_r[n] + prod_s[n];
          end
          state_r <= state_t'(state_r + 3'd1);
        end
        MAC3: begin
          for (int n = 0; n < 3; n++) begin
            acc_r[n] <= acc_r[n] + prod_s[n];
          end
          state_r <= CMP;
        end
        CMP: begin
          lv_r       <= acc_r;
          o_spikeout <= win_s;
          state_r    <= FIRE;
        end
        FIRE: begin
          o_spikeout <= 3'b000;
          pend_r     <= 1'b0;
          if (pend_r || any_event_s) begin
            state_r <= SNAP;
            o_busy  <= 1'b1;
          end else begin
            state_r <= IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          o_busy     <= 1'b0;
          o_spikeout <= 3'b000;
          pend_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_layer_infer.sv
// Self-checking bench for l2_layer_infer: directed vector table, hand-written
// multi-cycle sequences, and randomized events checked against a reference model.
module tb_l2_layer_infer;

  localparam int P  = 9;
  localparam int D  = 4;
  localparam int PW = 2 * P + 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [3:0]              ev = 4'b0000;
  logic [2:0][3:0][P-1:0]  w = '0;
  logic [2:0][PW-1:0]      thr = '0;
  logic [2:0]              spike;
  logic [4*P-1:0]          ts_o;
  logic [3*PW-1:0]         lv_o;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  l2_layer_infer #(.p_width(P), .p_decay_div(D)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_event      (ev),
    .i_weights    (w),
    .i_thresholds (thr),
    .o_spikeout   (spike),
    .o_ts         (ts_o),
    .o_lv         (lv_o),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // t = clocks since the computation started (-1 when idle); snapshot taken
  // one clock after start, result and spike six clocks after start, spike
  // cleared at seven, where a pending or fresh event restarts the sequence.
  int               m_t = -1;
  bit               m_pend = 1'b0;
  int               m_cnt = 0;
  int               m_ts [4];
  logic [3:0][P-1:0] m_ots = '0;
  logic [2:0][PW-1:0] m_lv = '0;
  logic [2:0]       m_spk = 3'b000;

  initial begin : model
    int told, lvn, best, bestv;
    for (int k = 0; k < 4; k++) m_ts[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_t = -1; m_pend = 1'b0; m_cnt = 0; m_ots = '0; m_lv = '0; m_spk = 3'b000;
        for (int k = 0; k < 4; k++) m_ts[k] = 0;
      end else begin
        told = m_t;
        m_cnt++;
        if (told < 0) begin
          if (|ev) m_t = 0;
        end else if (told < 6) begin
          m_t = told + 1;
          if (|ev) m_pend = 1'b1;
          if (told == 0) begin
            for (int k = 0; k < 4; k++) m_ots[k] = m_ts[k][P-1:0];
          end
          if (told == 5) begin
            best = -1; bestv = 0;
            for (int n = 0; n < 3; n++) begin
              lvn = 0;
              for (int k = 0; k < 4; k++) lvn += int'(w[n][k]) * int'(m_ots[k]);
              m_lv[n] = lvn[PW-1:0];
              if ((lvn > int'(thr[n])) && ((best < 0) || (lvn > bestv))) begin
                best = n; bestv = lvn;
              end
            end
            m_spk = (best >= 0) ? (3'b001 << best) : 3'b000;
          end
        end else begin
          m_spk = 3'b000;
          if (m_pend || (|ev)) m_t = 0;
          else m_t = -1;
          m_pend = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
          if (ev[k]) m_ts[k] = (1 << P) - 1;
          else if (((m_cnt % D) == 0) && (m_ts[k] > 0)) m_ts[k] = m_ts[k] - 1;
        end
      end
    end
  end

  // Scoreboard: every cycle the DUT outputs must equal the model.
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      chk("sb_spike", spike, m_spk);
      chk("sb_ts", ts_o, m_ots);
      chk("sb_lv", lv_o, m_lv);
      chk("sb_busy", busy, (m_t >= 0) ? 1'b1 : 1'b0);
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]             ev;
    logic [2:0][3:0][P-1:0] w;
    logic [2:0][PW-1:0]     thr;
    logic [4*P-1:0]         exp_ts;
    logic [2:0][PW-1:0]     exp_lv;
    logic [2:0]             exp_spk;
  } vec_t;

  vec_t vecs [5];

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    ev = 4'b0000;
    @(negedge clk);
    chk("reset_spike", spike, 3'b000);
    chk("reset_ts", ts_o, 36'h0);
    chk("reset_lv", lv_o, 60'h0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    w   = v.w;
    thr = v.thr;
    @(negedge clk) ev = v.ev;
    @(negedge clk) ev = 4'b0000;
    repeat (5) @(negedge clk);
    chk($sformatf("vec%0d_spike_early", idx), spike, 3'b000);
    @(negedge clk);
    chk($sformatf("vec%0d_spike", idx), spike, v.exp_spk);
    chk($sformatf("vec%0d_lv", idx), lv_o, v.exp_lv);
    chk($sformatf("vec%0d_ts", idx), ts_o, v.exp_ts);
    chk($sformatf("vec%0d_busy_fire", idx), busy, 1'b1);
    @(negedge clk);
    chk($sformatf("vec%0d_spike_end", idx), spike, 3'b000);
    chk($sformatf("vec%0d_busy_end", idx), busy, 1'b0);
  endtask

  initial begin : main
    logic [20:0] sp;
    int          nsp;
    int          g;

    vecs[0] = '{4'b0001, {12{9'h0FF}}, {3{20'h0FF00}}, 36'h0000001FF,
                {3{20'h1FD01}}, 3'b001};
    vecs[1] = '{4'b0001, {12{9'h0FF}}, {3{20'h20000}}, 36'h0000001FF,
                {3{20'h1FD01}}, 3'b000};
    vecs[2] = '{4'b1111, {{4{9'h001}}, {4{9'h1FF}}, {4{9'h001}}}, {3{20'h0FF00}},
                36'hFFFFFFFFF, {20'h007FC, 20'hFF004, 20'h007FC}, 3'b010};
    vecs[3] = '{4'b0010, {{4{9'h100}}, {4{9'h100}}, {4{9'h001}}}, {3{20'h00000}},
                36'h00003FE00, {20'h1FF00, 20'h1FF00, 20'h001FF}, 3'b010};
    vecs[4] = '{4'b0001, {12{9'h0FF}}, {20'h1FD00, 20'h1FD00, 20'h1FD01},
                36'h0000001FF, {3{20'h1FD01}}, 3'b010};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_vec(vecs[i], i);
    end

    // Decay: line 3 ages 40 clocks (10 ticks) before line 1 fires.
    do_reset();
    w = {12{9'h0FF}};
    thr = {3{20'h0FF00}};
    @(negedge clk) ev = 4'b0100;
    @(negedge clk) ev = 4'b0000;
    repeat (39) @(negedge clk);
    ev = 4'b0001;
    @(negedge clk) ev = 4'b0000;
    repeat (6) @(negedge clk);
    chk("decay_ts3_range", ((ts_o[26:18] >= 9'd500) && (ts_o[26:18] <= 9'd502)) ? 1'b1 : 1'b0, 1'b1);
    chk("decay_ts1", ts_o[8:0], 9'h1FF);
    repeat (2100) @(negedge clk);
    ev = 4'b0001;
    @(negedge clk) ev = 4'b0000;
    repeat (3) @(negedge clk);
    chk("decay_ts3_sat", ts_o[26:18], 9'h000);
    chk("decay_ts1_again", ts_o[8:0], 9'h1FF);
    repeat (6) @(negedge clk);

    // Pending event: second event 3 clocks after the first.
    do_reset();
    w = {12{9'h0FF}};
    thr = {3{20'h0FF00}};
    sp = '0;
    nsp = 0;
    @(negedge clk) ev = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ev = (i == 3) ? 4'b0010 : 4'b0000;
      sp[i] = |spike;
      if (|spike) nsp++;
      if (i == 14) begin
        chk("pend_ts_both", ((ts_o[8:0] != 9'h000) && (ts_o[17:9] != 9'h000)) ? 1'b1 : 1'b0, 1'b1);
      end
    end
    chk("pend_spike_e6", sp[7], 1'b1);
    chk("pend_spike_e13", sp[14], 1'b1);
    chk("pend_spike_count", nsp, 2);

    // Reset in the middle of a computation aborts it without a spike.
    do_reset();
    w = {12{9'h0FF}};
    thr = {3{20'h0FF00}};
    @(negedge clk) ev = 4'b0001;
    @(negedge clk) ev = 4'b0000;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    nsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|spike) nsp++;
    end
    chk("abort_no_spike", nsp, 0);
    chk("abort_lv", lv_o, 60'h0);
    chk("abort_ts", ts_o, 36'h0);
    chk("abort_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    run_vec(vecs[0], 10);

    // Randomized bursts against the reference model.
    for (int b = 0; b < 8; b++) begin
      @(negedge clk) ev = 4'b0000;
      g = 0;
      while (busy && (g < 40)) begin
        @(negedge clk);
        g++;
      end
      chk("rand_idle", busy, 1'b0);
      for (int n = 0; n < 3; n++) begin
        for (int k = 0; k < 4; k++) w[n][k] = 9'($urandom_range(0, 511));
        thr[n] = 20'($urandom_range(0, 900000));
      end
      repeat (150) begin
        @(negedge clk);
        ev = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
    end
    @(negedge clk) ev = 4'b0000;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
